fanout_fork_fifo: RTL and testbench



---
 rtl/fanout_fork_fifo_if.sv | 25 ++
 rtl/fanout_fork_fifo.sv | 68 ++++++
 tb/tb_fanout_fork_fifo.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fanout_fork_fifo_if.sv
// Stream bundle for the fanout fork FIFO: one upstream producer, NUM_OUT consumers
// sharing a single head word, plus the occupancy status.
interface fanout_fork_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_OUT    = 7,
    parameter int DEPTH      = 2
);
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    valid_in;
    logic                    ready_out;
    logic [DATA_WIDTH-1:0]   data_out;
    logic [NUM_OUT-1:0]      valid_out;
    logic [NUM_OUT-1:0]      ready_in;
    logic [$clog2(DEPTH):0]  occupancy;

    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out, occupancy
    );

    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, data_out, valid_out, occupancy
    );
endinterface

// File: rtl/fanout_fork_fifo.sv
// Registered ready/valid buffer feeding up to NUM_OUT consumers with an eager fork:
// each consumer takes the head independently; the head retires once all enabled ones have.
module fanout_fork_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_OUT    = 7,
    parameter int DEPTH      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic [NUM_OUT-1:0] cfg_fanout_en,
    fanout_fork_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [NUM_OUT-1:0]    taken;
    logic [NUM_OUT-1:0]    fire;
    logic                  head_valid;
    logic                  done;
    logic                  push;
    logic                  pop;

    // ready_out looks only at count, so no ready_in -> ready_out path exists
    always_comb begin
        head_valid    = (count != '0);
        bus.ready_out = (count < CNT_W'(DEPTH)) & clk_en;
        bus.valid_out = cfg_fanout_en & ~taken & {NUM_OUT{head_valid & clk_en}};
        fire          = bus.valid_out & bus.ready_in;
        done          = &(~cfg_fanout_en | taken | fire);
        push          = bus.valid_in & bus.ready_out;
        pop           = head_valid & done & clk_en;
        bus.data_out  = storage[rd_ptr];
        bus.occupancy = count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < $unsigned(DEPTH); i++) begin
                storage[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            taken  <= '0;
        end else if (clk_en) begin
            if (push) begin
                storage[wr_ptr] <= bus.data_in;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                taken  <= '0;
            end else if (head_valid) begin
                taken <= taken | fire;
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fanout_fork_fifo.sv
// Directed plus randomized bench for fanout_fork_fifo, checked against a queue-based
// model of the stored words and a per-consumer record of who has taken the head.
module tb_fanout_fork_fifo;
    localparam int DW    = 16;
    localparam int NO    = 7;
    localparam int DEPTH = 2;

    logic          clk;
    logic          reset;
    logic          clk_en;
    logic [NO-1:0] cfg;

    fanout_fork_fifo_if #(.DATA_WIDTH(DW), .NUM_OUT(NO), .DEPTH(DEPTH)) bus ();

    fanout_fork_fifo #(.DATA_WIDTH(DW), .NUM_OUT(NO), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .cfg_fanout_en (cfg),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // model state: words held by the buffer (head first) and who has taken the head
    logic [DW-1:0] q[$];
    logic [DW-1:0] popped[$];
    logic [NO-1:0] mt;
    int unsigned   fire_cnt [NO];
    int unsigned   cyc = 0;
    logic          last_push;
    logic          last_pop;
    logic [NO-1:0] last_valid;
    int unsigned   last_occ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        popped.delete();
        for (int i = 0; i < NO; i++) fire_cnt[i] = 0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, step past the rising edge.
    task automatic cycle();
        logic [NO-1:0] ev;
        logic [NO-1:0] f;
        logic          er;
        logic          all_taken;
        @(negedge clk);
        er = (q.size() < DEPTH) && clk_en;
        ev = '0;
        for (int i = 0; i < NO; i++) ev[i] = (q.size() != 0) && cfg[i] && !mt[i] && clk_en;
        chk("ready_out", {31'd0, bus.ready_out}, {31'd0, er});
        chk("valid_out", {25'd0, bus.valid_out}, {25'd0, ev});
        chk("occupancy", {30'd0, bus.occupancy}, q.size());
        if (q.size() != 0) chk("data_out", {16'd0, bus.data_out}, {16'd0, q[0]});
        last_valid = bus.valid_out;
        last_occ   = q.size();
        f = ev & bus.ready_in;
        all_taken = 1'b1;
        for (int i = 0; i < NO; i++) begin
            if (f[i]) fire_cnt[i]++;
            if (cfg[i] && !mt[i] && !f[i]) all_taken = 1'b0;
        end
        last_pop  = (q.size() != 0) && all_taken && clk_en;
        last_push = bus.valid_in && er;
        if (last_pop) begin
            popped.push_back(q.pop_front());
            mt = '0;
        end else if (q.size() != 0) begin
            mt = mt | f;
        end
        if (last_push) q.push_back(bus.data_in);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // upstream must hold valid/data while stalled
    logic          pend = 1'b0;
    logic [DW-1:0] pend_data;
    always @(posedge clk) begin
        if (pend && !reset) begin
            assert (bus.valid_in && bus.data_in == pend_data)
                else $error("upstream hold violated");
        end
        pend      <= bus.valid_in && !bus.ready_out && !reset;
        pend_data <= bus.data_in;
    end

    int unsigned   pop1_cyc;
    int unsigned   push3_cyc;
    int unsigned   n;
    int unsigned   maxocc;
    logic          anyv;

    initial begin
        reset        = 1'b1;
        clk_en       = 1'b1;
        cfg          = '0;
        bus.data_in  = '0;
        bus.valid_in = 1'b0;
        bus.ready_in = '0;
        mt           = '0;
        #2;
        chk("rst_ready", {31'd0, bus.ready_out}, 32'd1);
        chk("rst_valid", {25'd0, bus.valid_out}, 32'd0);
        chk("rst_occ",   {30'd0, bus.occupancy}, 32'd0);
        chk("rst_data",  {16'd0, bus.data_out},  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // T1: single word to two consumers, all ready
        clear_stats();
        cfg = 7'b0000011; bus.ready_in = '1;
        bus.valid_in = 1'b1; bus.data_in = 16'hA5A5;
        cycle();
        bus.valid_in = 1'b0;
        cycle();
        chk("t1_valid", {25'd0, last_valid}, 32'h03);
        chk("t1_pop", {31'd0, last_pop}, 32'd1);
        cycle();
        chk("t1_occ", last_occ, 32'd0);

        // T2: staggered acceptance by three consumers
        clear_stats();
        cfg = 7'b0000111; bus.ready_in = '0;
        bus.valid_in = 1'b1; bus.data_in = 16'h1234;
        cycle();
        bus.valid_in = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            bus.ready_in = (c == 1) ? 7'b0000001 : (c == 3) ? 7'b0000010 :
                           (c == 5) ? 7'b0000100 : 7'b0000000;
            cycle();
            chk("t2_pop_cycle", {31'd0, last_pop}, {31'd0, (c == 5)});
        end
        for (int i = 0; i < 3; i++) chk("t2_once", fire_cnt[i], 32'd1);

        // T3: fill with stalled consumers, then drain in order
        clear_stats();
        cfg = 7'b0000011; bus.ready_in = '0;
        bus.valid_in = 1'b1; bus.data_in = 16'h0001;
        cycle();
        bus.data_in = 16'h0002;
        cycle();
        bus.data_in = 16'h0003;
        cycle();
        chk("t3_stall", {31'd0, last_push}, 32'd0);
        chk("t3_occ", last_occ, 32'd2);
        bus.ready_in = '1;
        pop1_cyc = 0; push3_cyc = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (last_pop && pop1_cyc == 0) pop1_cyc = cyc;
            if (last_push) begin
                push3_cyc = cyc;
                bus.valid_in = 1'b0;
            end
        end
        chk("t3_npop", popped.size(), 32'd3);
        chk("t3_w0", {16'd0, popped[0]}, 32'h0001);
        chk("t3_w1", {16'd0, popped[1]}, 32'h0002);
        chk("t3_w2", {16'd0, popped[2]}, 32'h0003);
        chk("t3_lat", push3_cyc - pop1_cyc, 32'd1);

        // T4: sink mode streaming
        clear_stats();
        cfg = '0; bus.ready_in = '0;
        bus.valid_in = 1'b1; bus.data_in = 16'h0010;
        n = 0; anyv = 1'b0; maxocc = 0;
        for (int c = 0; c < 14; c++) begin
            cycle();
            anyv = anyv | (|last_valid);
            if (last_occ > maxocc) maxocc = last_occ;
            if (last_push) begin
                n++;
                if (n == 4) bus.valid_in = 1'b0;
                else bus.data_in = bus.data_in + 16'd1;
            end
        end
        chk("t4_novalid", {31'd0, anyv}, 32'd0);
        chk("t4_accepted", n, 32'd4);
        chk("t4_maxocc", {31'd0, (maxocc <= 1)}, 32'd1);
        chk("t4_popped", popped.size(), 32'd4);

        // T5: asynchronous reset with a partially taken head
        cfg = 7'b0000011; bus.ready_in = '0;
        bus.valid_in = 1'b1; bus.data_in = 16'h0A0A;
        cycle();
        bus.data_in = 16'h0B0B;
        cycle();
        bus.valid_in = 1'b0;
        bus.ready_in = 7'b0000001;
        cycle();
        bus.ready_in = '0;
        cycle();
        chk("t5_pre_valid", {25'd0, last_valid}, 32'h02);
        reset = 1'b1;
        #1;
        chk("t5_rst_ready", {31'd0, bus.ready_out}, 32'd1);
        chk("t5_rst_valid", {25'd0, bus.valid_out}, 32'd0);
        chk("t5_rst_occ",   {30'd0, bus.occupancy}, 32'd0);
        chk("t5_rst_data",  {16'd0, bus.data_out},  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete(); mt = '0;
        clear_stats();
        cfg = 7'b0000001; bus.ready_in = '1;
        bus.valid_in = 1'b1; bus.data_in = 16'h0BEE;
        cycle();
        bus.valid_in = 1'b0;
        cycle();
        cycle();
        chk("t5_c0_seen", fire_cnt[0], 32'd1);
        chk("t5_word", {16'd0, popped[0]}, 32'h0BEE);

        // T6: clock enable low mid-word
        clear_stats();
        cfg = 7'b0000111; bus.ready_in = '0;
        bus.valid_in = 1'b1; bus.data_in = 16'h7777;
        cycle();
        bus.valid_in = 1'b0;
        clk_en = 1'b0; bus.ready_in = '1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t6_frozen_occ", last_occ, 32'd1);
        end
        chk("t6_nofire", fire_cnt[0] + fire_cnt[1] + fire_cnt[2], 32'd0);
        clk_en = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < 3; i++) chk("t6_once", fire_cnt[i], 32'd1);
        chk("t6_word", {16'd0, popped[0]}, 32'h7777);

        // Random traffic, with config changes mid-word and clock-enable gaps
        for (int c = 0; c < 500; c++) begin
            if (!(bus.valid_in && !last_push)) begin
                bus.valid_in = ($urandom_range(0, 2) != 0);
                bus.data_in  = DW'($urandom);
            end
            bus.ready_in = NO'($urandom);
            if ($urandom_range(0, 7) == 0) cfg = NO'($urandom);
            clk_en = ($urandom_range(0, 9) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
